// File: rtl/mux_scan_seq.sv
// mux_scan_seq: sweeps a 32:1 mux select, serializes and re-checks the word.
// Optional `MUX_SCAN_PARITY_EN adds a parity output over the sampled bits.
module mux_scan_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data_in,
  output logic        ready,
  output logic [31:0] mux_i,
  output logic [4:0]  mux_s,
  input  logic        mux_y,
  output logic        ser_valid,
  output logic        ser_bit,
  output logic        done,
  output logic [31:0] word_out,
`ifdef MUX_SCAN_PARITY_EN
  output logic        parity,
`endif
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;

  // Word as it will look once this cycle's sample is stored.
  logic [31:0] next_word;

  always_comb begin
    next_word = word_out;
    next_word[mux_s] = mux_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      mux_i     <= '0;
      mux_s     <= '0;
      ser_valid <= 1'b0;
      ser_bit   <= 1'b0;
      done      <= 1'b0;
      word_out  <= '0;
      err       <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= SHIFT;
            ready    <= 1'b0;
            mux_i    <= data_in;
            mux_s    <= '0;
            word_out <= '0;
            err      <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          ser_bit   <= mux_y;
          ser_valid <= 1'b1;
          word_out  <= next_word;
          err       <= (next_word != mux_i);
`ifdef MUX_SCAN_PARITY_EN
          parity    <= parity ^ mux_y;
`endif
          if (mux_s == 5'd31) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            mux_s <= mux_s + 5'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          ready     <= 1'b1;
          ser_valid <= 1'b0;
          done      <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Self-checking bench for mux_scan_seq with a behavioural mux32 and
// a word-level reference model.
module tb_mux_scan_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic        ready;
  logic [31:0] mux_i;
  logic [4:0]  mux_s;
  logic        mux_y;
  logic        ser_valid;
  logic        ser_bit;
  logic        done;
  logic [31:0] word_out;
  logic        err;
`ifdef MUX_SCAN_PARITY_EN
  logic        parity;
`endif
  logic        fault17 = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural mux32 with an optional stuck-at-0 on select 17.
  assign mux_y = (fault17 && mux_s == 5'd17) ? 1'b0 : mux_i[mux_s];

  mux_scan_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .ready     (ready),
    .mux_i     (mux_i),
    .mux_s     (mux_s),
    .mux_y     (mux_y),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .done      (done),
    .word_out  (word_out),
`ifdef MUX_SCAN_PARITY_EN
    .parity    (parity),
`endif
    .err       (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".ready"}, {31'b0, ready}, 32'd1);
    chk({tag, ".mux_i"}, mux_i, 32'd0);
    chk({tag, ".mux_s"}, {27'b0, mux_s}, 32'd0);
    chk({tag, ".ser_valid"}, {31'b0, ser_valid}, 32'd0);
    chk({tag, ".ser_bit"}, {31'b0, ser_bit}, 32'd0);
    chk({tag, ".done"}, {31'b0, done}, 32'd0);
    chk({tag, ".word_out"}, word_out, 32'd0);
    chk({tag, ".err"}, {31'b0, err}, 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    chk({tag, ".parity"}, {31'b0, parity}, 32'd0);
`endif
  endtask

  // One full transfer; model: sampled bit k = w[k] unless the mux is faulty.
  task automatic transfer(input logic [31:0] w,
                          input logic fault,
                          input logic pulse);
    logic [31:0] exp_word;
    int wait_n;
    exp_word = w;
    if (fault) exp_word[17] = 1'b0;
    wait_n = 0;
    while (!ready && wait_n < 50) begin
      tick();
      wait_n++;
    end
    chk("ready_before_start", {31'b0, ready}, 32'd1);
    fault17 = fault;
    start = 1'b1;
    data_in = w;
    tick();
    start = 1'b0;
    data_in = $urandom;
    chk("accept.ready", {31'b0, ready}, 32'd0);
    chk("accept.mux_i", mux_i, w);
    chk("accept.mux_s", {27'b0, mux_s}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      tick();
      start = 1'b0;
      if (pulse && (k == 4 || k == 19)) begin
        start = 1'b1;
        data_in = ~w;
      end
      chk("ser_valid", {31'b0, ser_valid}, 32'd1);
      chk("ser_bit", {31'b0, ser_bit}, {31'b0, exp_word[k]});
      chk("done", {31'b0, done}, {31'b0, k == 31});
      chk("ready_busy", {31'b0, ready}, 32'd0);
    end
    start = 1'b0;
    chk("word_out", word_out, exp_word);
    chk("err", {31'b0, err}, {31'b0, exp_word != w});
    chk("mux_i_stable", mux_i, w);
`ifdef MUX_SCAN_PARITY_EN
    chk("parity", {31'b0, parity}, {31'b0, ^exp_word});
`endif
    tick();
    chk("after.ready", {31'b0, ready}, 32'd1);
    chk("after.ser_valid", {31'b0, ser_valid}, 32'd0);
    chk("after.done", {31'b0, done}, 32'd0);
    chk("after.mux_s", {27'b0, mux_s}, 32'd31);
    chk("after.word_out", word_out, exp_word);
    chk("after.err", {31'b0, err}, {31'b0, exp_word != w});
    fault17 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    start = 1'b0;
    data_in = '0;
    tick();
    tick();
    chk_reset_state("reset");
    rst = 1'b0;
    tick();

    transfer(32'hCCCCCCCC, 1'b0, 1'b0);
    transfer(32'h00000001, 1'b0, 1'b0);
    transfer(32'hFFFFFFFF, 1'b1, 1'b0);

    // Ignored starts, then an immediate back-to-back accept.
    transfer($urandom, 1'b0, 1'b1);
    transfer($urandom, 1'b0, 1'b0);

    // Reset while bit 10 is on ser_bit.
    w = $urandom;
    start = 1'b1;
    data_in = w;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 10; k++) tick();
    chk("mid.ser_bit10", {31'b0, ser_bit}, {31'b0, w[10]});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("midrst");
    tick();
    chk("midrst.no_done", {31'b0, done}, 32'd0);
    chk("midrst.ser_valid", {31'b0, ser_valid}, 32'd0);
    transfer($urandom, 1'b0, 1'b0);

    // Reset and start on the same edge.
    rst = 1'b1;
    start = 1'b1;
    data_in = 32'hA5A5A5A5;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk_reset_state("rst_start");
    tick();
    chk("rst_start.ser_valid2", {31'b0, ser_valid}, 32'd0);
    chk("rst_start.ready2", {31'b0, ready}, 32'd1);

    for (int n = 0; n < 4; n++) transfer($urandom, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
